// File: rtl/sprite_palette_bank.sv
// Multi-bank runtime-writable colour palette: maps a pixel index to 12-bit RGB
// through a frame-synchronously selected bank, with damage-flash and transparency.
module sprite_palette_bank #(
    parameter int IDX_W        = 4,
    parameter int CH_W         = 4,
    parameter int NUM_PAL      = 4,
    parameter int TRANSP_EN    = 1,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_FRAMES = 4,
    localparam int PAL_W       = $clog2(NUM_PAL)
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                pix_valid,
    input  logic [IDX_W-1:0]    index,
    input  logic [PAL_W-1:0]    pal_sel,
    input  logic                frame_start,
    input  logic                flash_en,
    input  logic                wr_en,
    input  logic [PAL_W-1:0]    wr_pal,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [3*CH_W-1:0]   wr_rgb,
    output logic                out_valid,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    output logic                transparent,
    output logic [PAL_W-1:0]    active_pal
);

    localparam int DEPTH = NUM_PAL << IDX_W;
    localparam int RGB_W = 3 * CH_W;
    localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

    logic [RGB_W-1:0] mem [DEPTH];

    // NOTE: the palette is a flop array, not a RAM, so clearing it on reset is legal and required.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[{wr_pal, wr_idx}] <= wr_rgb;
        end
    end

    logic [PAL_W-1:0] base_pal, base_nxt, eff_nxt;
    logic             flash_on, flash_nxt;
    logic             phase, phase_nxt;
    logic [CNT_W-1:0] frame_cnt, cnt_nxt;

    // NOTE: every combinational output gets a hold default first so no latch is inferred.
    always_comb begin
        base_nxt  = base_pal;
        flash_nxt = flash_on;
        phase_nxt = phase;
        cnt_nxt   = frame_cnt;
        if (frame_start) begin
            base_nxt  = pal_sel;
            flash_nxt = flash_en;
            if (!flash_en) begin
                cnt_nxt   = '0;
                phase_nxt = 1'b0;
            end else if (frame_cnt == CNT_LAST) begin
                cnt_nxt   = '0;
                phase_nxt = ~phase;
            end else begin
                cnt_nxt   = frame_cnt + 1'b1;
            end
        end
        eff_nxt = (flash_nxt && phase_nxt) ? (base_nxt ^ PAL_W'(1)) : base_nxt;
    end

    // active_pal is loaded from next-state so it is valid the cycle right after frame_start.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            base_pal   <= '0;
            flash_on   <= 1'b0;
            phase      <= 1'b0;
            frame_cnt  <= '0;
            active_pal <= '0;
        end else begin
            base_pal   <= base_nxt;
            flash_on   <= flash_nxt;
            phase      <= phase_nxt;
            frame_cnt  <= cnt_nxt;
            active_pal <= eff_nxt;
        end
    end

    logic             s1_valid;
    logic             s1_transp;
    logic [RGB_W-1:0] s1_rgb;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid    <= 1'b0;
            s1_transp   <= 1'b0;
            s1_rgb      <= '0;
            out_valid   <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            transparent <= 1'b0;
        end else begin
            s1_valid  <= pix_valid;
            s1_transp <= (TRANSP_EN != 0) && (index == IDX_W'(TRANSP_IDX));
            s1_rgb    <= mem[{active_pal, index}];
            out_valid <= s1_valid;
            if (s1_transp) begin
                {red, green, blue} <= '0;
                transparent        <= 1'b1;
            end else begin
                {red, green, blue} <= s1_rgb;
                transparent        <= 1'b0;
            end
        end
    end

endmodule
